// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan controller.
// Holds the scan state enum, the all-off drive constants and the hex-to-segment
// table. Segment patterns are active-low and packed as {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Anode pattern with only the selected digit pulled low
  function automatic logic [3:0] an_select(input logic [1:0] d);
    logic [3:0] pattern;
    pattern    = AN_OFF;
    pattern[d] = 1'b0;
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex to active-low 7-segment decoder.
// Looks the pattern up in the shared table so there is one source of truth.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Straight table lookup, full 0..F coverage
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a four-digit 7-segment
// display. Walks the digit select 3,2,1,0 with an all-dark gap between digits,
// latching the decoded digit value only when the anode turns on, so a lit
// anode never shows a stale pattern.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading
// zeros on digits 3..1 (digit 0 always displays).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] idnum,
  output logic [1:0] digit,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_RELOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic [6:0]       dec_seg;
  logic             blank_zero;

  seg7_decode u_decode (
    .hex (idnum),
    .seg (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // A zero on digits 3..1 stays dark while no nonzero digit has been seen this frame
  always_comb begin
    blank_zero = lead_zero && (idnum == 4'd0) && (digit != 2'd0);
  end
`else
  // Every digit displays when leading-zero suppression is not built in
  always_comb begin
    blank_zero = 1'b0;
  end
`endif

  // Scan FSM: one down-counter reloaded on each state entry, registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      en_q  <= 1'b0;
      digit <= 2'b11;
      seg   <= SEG_OFF;
      an    <= AN_OFF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lead_zero <= 1'b0;
`endif
    end else begin
      en_q <= en;
      if (!en_q) begin
        state <= IDLE;
        cnt   <= '0;
        seg   <= SEG_OFF;
        an    <= AN_OFF;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= BLANK_RELOAD;
            digit <= 2'b11;
            an    <= AN_OFF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lead_zero <= 1'b1;
`endif
          end
          BLANK: begin
            if (cnt == '0) begin
              state <= SHOW;
              cnt   <= ON_RELOAD;
              if (blank_zero) begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
              end else begin
                seg <= dec_seg;
                an  <= an_select(digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (idnum != 4'd0) begin
                  lead_zero <= 1'b0;
                end
`endif
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          SHOW: begin
            if (cnt == '0) begin
              state <= BLANK;
              cnt   <= BLANK_RELOAD;
              digit <= digit - 2'd1;
              an    <= AN_OFF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
              if (digit == 2'd0) begin
                lead_zero <= 1'b1;
              end
`endif
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            seg   <= SEG_OFF;
            an    <= AN_OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl with
// ON_CYCLES=4 and BLANK_CYCLES=2. The digit memory is modelled as a 16-bit
// word, nibble 3 leftmost. Works with or without SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_ctrl;

  localparam int ON = 4;
  localparam int BL = 2;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [3:0] idnum;
  logic [1:0] digit;
  logic [6:0] seg;
  logic [3:0] an;
  logic [15:0] mem;

  int compared;
  int mismatched;

  seg7_scan_ctrl #(
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .idnum   (idnum),
    .digit   (digit),
    .seg     (seg),
    .an      (an)
  );

  // Combinational digit memory beside the controller
  assign idnum = 4'(mem >> {digit, 2'b00});

  // Free-running clock, active edge is posedge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive all inputs at once (called just after a negedge)
  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [15:0] mem_v);
    reset_n = rst_v;
    en      = en_v;
    mem     = mem_v;
  endtask

  // Compare anode and segment drive against expectations
  task automatic checkOutput(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    compared++;
    assert (an === exp_an) else begin
      mismatched++;
      $error("[TB] FAIL %s an: observed %b expected %b", tag, an, exp_an);
    end
    compared++;
    assert (seg === exp_seg) else begin
      mismatched++;
      $error("[TB] FAIL %s seg: observed %h expected %h", tag, seg, exp_seg);
    end
  endtask

  // Compare digit select against expectation
  task automatic checkDigit(input string tag, input logic [1:0] exp_digit);
    compared++;
    assert (digit === exp_digit) else begin
      mismatched++;
      $error("[TB] FAIL %s digit: observed %0d expected %0d", tag, digit, exp_digit);
    end
  endtask

  // Check one full frame; the next posedge must enter BLANK for digit 3.
  // segs = {s3,s2,s1,s0}; lit[d]=0 means digit d is dark in its SHOW slot.
  task automatic checkFrame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                            input logic [6:0] prev_seg);
    logic [6:0] prev;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    prev = prev_seg;
    for (int d = 3; d >= 0; d--) begin
      for (int c = 0; c < BL; c++) begin
        @(negedge clk);
        checkOutput($sformatf("%s blank d%0d c%0d", tag, d, c), 4'hF, prev);
        checkDigit($sformatf("%s blank d%0d c%0d", tag, d, c), 2'(d));
      end
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      if (lit[d]) begin
        exp_an[d] = 1'b0;
        exp_seg   = segs[d*7 +: 7];
      end
      for (int c = 0; c < ON; c++) begin
        @(negedge clk);
        checkOutput($sformatf("%s show d%0d c%0d", tag, d, c), exp_an, exp_seg);
        checkDigit($sformatf("%s show d%0d c%0d", tag, d, c), 2'(d));
      end
      prev = exp_seg;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset with en high: dark, digit 3
    applyStimulus(1'b0, 1'b1, 16'h1119);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset", 4'hF, 7'h7F);
      checkDigit("reset", 2'd3);
    end

    // Release: en sampled, then BLANK, SHOW three cycles after release
    applyStimulus(1'b1, 1'b1, 16'h1119);
    @(negedge clk);
    checkOutput("release idle", 4'hF, 7'h7F);
    checkFrame("1119 f1", {7'h79, 7'h79, 7'h79, 7'h10}, 4'b1111, 7'h7F);
    checkFrame("1119 f2", {7'h79, 7'h79, 7'h79, 7'h10}, 4'b1111, 7'h10);

    // Digit 3 again: idnum change mid-SHOW ignored, then en dropped in SHOW cycle 2
    repeat (BL) begin
      @(negedge clk);
      checkOutput("pre-drop blank", 4'hF, 7'h10);
    end
    @(negedge clk);
    checkOutput("show c1", 4'b0111, 7'h79);
    applyStimulus(1'b1, 1'b1, 16'h8119);
    @(negedge clk);
    checkOutput("idnum change held", 4'b0111, 7'h79);
    applyStimulus(1'b1, 1'b0, 16'h8119);
    @(negedge clk);
    checkOutput("en fall sampled", 4'b0111, 7'h79);
    repeat (3) begin
      @(negedge clk);
      checkOutput("en low dark", 4'hF, 7'h7F);
    end

    // Re-raise en with full hex pattern: restart at digit 3
    applyStimulus(1'b1, 1'b1, 16'hABCF);
    @(negedge clk);
    checkOutput("re-raise idle", 4'hF, 7'h7F);
    checkFrame("ABCF", {7'h08, 7'h03, 7'h46, 7'h0E}, 4'b1111, 7'h7F);

    // Leading-zero patterns (chained frames)
    applyStimulus(1'b1, 1'b1, 16'h0052);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkFrame("0052", {7'h40, 7'h40, 7'h12, 7'h24}, 4'b0011, 7'h0E);
`else
    checkFrame("0052", {7'h40, 7'h40, 7'h12, 7'h24}, 4'b1111, 7'h0E);
`endif
    applyStimulus(1'b1, 1'b1, 16'h0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkFrame("0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0001, 7'h24);
`else
    checkFrame("0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 7'h24);
`endif
    applyStimulus(1'b1, 1'b1, 16'h1005);
    checkFrame("1005", {7'h79, 7'h40, 7'h40, 7'h12}, 4'b1111, 7'h40);

    // Run to the first BLANK cycle of digit 1, then reset
    repeat (2 * (BL + ON)) @(negedge clk);
    @(negedge clk);
    checkOutput("blank d1", 4'hF, 7'h40);
    checkDigit("blank d1", 2'd1);
    applyStimulus(1'b0, 1'b1, 16'h1005);
    repeat (3) begin
      @(negedge clk);
      checkOutput("mid-blank reset", 4'hF, 7'h7F);
      checkDigit("mid-blank reset", 2'd3);
    end
    applyStimulus(1'b1, 1'b1, 16'h1005);
    @(negedge clk);
    checkOutput("post-reset idle", 4'hF, 7'h7F);
    checkFrame("1005 after reset", {7'h79, 7'h40, 7'h40, 7'h12}, 4'b1111, 7'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
